// File: rtl/simon_core_param.sv
// Iterative SIMON core, one round per cycle; every variant from one source via N/M/T/ZSEL.
// Optional decrypt path: define SIMON_DEC_EN (otherwise enc_dec is ignored and every block is encrypted).
//
// state  | meaning
// NOKEY  | no valid key schedule, waiting for a key
// KEYEXP | expanding one round key per cycle into the key store
// READY  | schedule valid, accepting a new key or a block
// ROUND  | running T rounds on the captured block
// DONE   | result valid on outData, waiting for readData
module simon_core_param #(
  parameter int N    = 64,
  parameter int M    = 4,
  parameter int T    = 72,
  parameter int ZSEL = 3,
  parameter int Cb   = 7
) (
  input  logic                clk,
  input  logic                R,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] key,
  input  logic                newData,
  input  logic                enc_dec,
  input  logic [1:0][N-1:0]   inData,
  input  logic                readData,
  output logic                loadKey,
  output logic                loadData,
  output logic                doneKey,
  output logic                doneData,
  output logic [1:0][N-1:0]   outData
);

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] ZC = (ZSEL == 0) ? Z0 : (ZSEL == 1) ? Z1 :
                               (ZSEL == 2) ? Z2 : (ZSEL == 3) ? Z3 : Z4;
  localparam logic [Cb-1:0] LAST = Cb'(T - 1);
  localparam logic [Cb-1:0] CM   = Cb'(M);

  typedef enum logic [2:0] {S_NOKEY, S_KEYEXP, S_READY, S_ROUND, S_DONE} state_t;

  state_t        state, state_nx;
  logic [Cb-1:0] count;
  logic [N-1:0]  ks [T];
  logic [N-1:0]  x, y, x_nx, y_nx;
  logic [N-1:0]  kx_tmp, k_new;
  logic [5:0]    z_idx;
  int            zi;
  logic          key_cap, data_cap;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return rol(v, N - s);
  endfunction

  function automatic logic [N-1:0] f_fn(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= S_NOKEY;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    loadKey  = 1'b0;
    loadData = 1'b0;
    key_cap  = 1'b0;
    data_cap = 1'b0;
    case (state)
      S_NOKEY: begin
        loadKey = 1'b1;
        if (newKey) begin
          key_cap  = 1'b1;
          state_nx = S_KEYEXP;
        end
      end
      S_KEYEXP: if (count == LAST) state_nx = S_READY;
      S_READY: begin
        loadKey  = 1'b1;
        loadData = 1'b1;
        // A simultaneous key wins; the block is dropped.
        if (newKey) begin
          key_cap  = 1'b1;
          state_nx = S_KEYEXP;
        end else if (newData) begin
          data_cap = 1'b1;
          state_nx = S_ROUND;
        end
      end
      S_ROUND: if (count == LAST) state_nx = S_DONE;
      S_DONE:  if (readData) state_nx = S_READY;
      default: state_nx = S_NOKEY;
    endcase
  end

  // Key expansion of slot count from slots count-M..count-1.
  always_comb begin
    kx_tmp = ror(ks[count - Cb'(1)], 3);
    if (M == 4) kx_tmp = kx_tmp ^ ks[count - Cb'(3)];
    kx_tmp = kx_tmp ^ ror(kx_tmp, 1);
    zi = int'(count) - M;
    if (zi >= 62) zi = zi - 62;
    z_idx = 6'(61 - zi);
    k_new = ~ks[count - CM] ^ kx_tmp ^ N'(3) ^ {{(N-1){1'b0}}, ZC[z_idx]};
  end

`ifdef SIMON_DEC_EN
  logic mode_enc;

  always_comb begin
    x_nx = y ^ f_fn(x) ^ ks[count];
    y_nx = x;
    if (!mode_enc) begin
      x_nx = y;
      y_nx = x ^ f_fn(y) ^ ks[LAST - count];
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R)             mode_enc <= 1'b1;
    else if (data_cap) mode_enc <= enc_dec;
  end
`else
  logic unused_enc_dec;
  assign unused_enc_dec = enc_dec;

  always_comb begin
    x_nx = y ^ f_fn(x) ^ ks[count];
    y_nx = x;
  end
`endif

  always_ff @(posedge clk) begin
    if (key_cap) begin
      for (int i = 0; i < M; i++) ks[i] <= key[i];
    end else if (state == S_KEYEXP) begin
      ks[count] <= k_new;
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      count    <= '0;
      x        <= '0;
      y        <= '0;
      outData  <= '0;
      doneKey  <= 1'b0;
      doneData <= 1'b0;
    end else if (key_cap) begin
      count   <= CM;
      doneKey <= 1'b0;
    end else if (data_cap) begin
      x     <= inData[1];
      y     <= inData[0];
      count <= '0;
    end else begin
      case (state)
        S_KEYEXP: begin
          if (count == LAST) begin
            count   <= '0;
            doneKey <= 1'b1;
          end else begin
            count <= count + Cb'(1);
          end
        end
        S_ROUND: begin
          x <= x_nx;
          y <= y_nx;
          if (count == LAST) begin
            count    <= '0;
            outData  <= {x_nx, y_nx};
            doneData <= 1'b1;
          end else begin
            count <= count + Cb'(1);
          end
        end
        S_DONE: if (readData) doneData <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_core_param.sv
// Bench for simon_core_param: SIMON128/256 instance checked every cycle against a timeline model,
// plus a SIMON32/64 instance checked against the published vector.
module tb_simon_core_param;
  localparam int N0 = 64;
  localparam int M0 = 4;
  localparam int T0 = 72;

  logic clk = 1'b0;
  logic R;
  logic newKey, newData, enc_dec, readData;
  logic [3:0][63:0] key;
  logic [1:0][63:0] inData, outData;
  logic loadKey, loadData, doneKey, doneData;

  logic s_newKey, s_newData, s_enc, s_read;
  logic [3:0][15:0] s_key;
  logic [1:0][15:0] s_in, s_out;
  logic s_lk, s_ld, s_dk, s_dd;

  // SIMON128/256 takes sequence z4.
  simon_core_param #(.N(64), .M(4), .T(72), .ZSEL(4), .Cb(7)) dut (
    .clk(clk), .R(R), .newKey(newKey), .key(key), .newData(newData), .enc_dec(enc_dec),
    .inData(inData), .readData(readData), .loadKey(loadKey), .loadData(loadData),
    .doneKey(doneKey), .doneData(doneData), .outData(outData));

  simon_core_param #(.N(16), .M(4), .T(32), .ZSEL(0), .Cb(5)) dut_s (
    .clk(clk), .R(R), .newKey(s_newKey), .key(s_key), .newData(s_newData), .enc_dec(s_enc),
    .inData(s_in), .readData(s_read), .loadKey(s_lk), .loadData(s_ld),
    .doneKey(s_dk), .doneData(s_dd), .outData(s_out));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic exp_lk, exp_ld, exp_dk, exp_dd;
  logic [127:0] exp_out;
  logic [63:0] rk [0:71];
  logic [61:0] zt [0:4];
  int cnt;

  localparam logic [255:0] K0 = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
                                  64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
  localparam logic [127:0] PT = {64'h74206e69206d6f6f, 64'h6d69732061207369};
  localparam logic [127:0] CT = {64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868};

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("loadKey",  128'(loadKey),  128'(exp_lk));
      check("loadData", 128'(loadData), 128'(exp_ld));
      check("doneKey",  128'(doneKey),  128'(exp_dk));
      check("doneData", 128'(doneData), 128'(exp_dd));
      check("outData",  128'(outData),  exp_out);
    end
  end

  function automatic logic [63:0] msk(input int n);
    return (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n);
    logic [63:0] w;
    w = v & msk(n);
    return ((w << s) | (w >> (n - s))) & msk(n);
  endfunction

  function automatic logic [63:0] ff(input logic [63:0] v, input int n);
    return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
  endfunction

  task automatic expand(input logic [3:0][63:0] kw, input int n, input int m, input int t, input int zs);
    logic [63:0] tmp;
    logic [61:0] zw;
    logic zb;
    zw = zt[zs];
    for (int i = 0; i < m; i++) rk[i] = kw[i] & msk(n);
    for (int i = 0; i < t - m; i++) begin
      tmp = rotl(rk[i+m-1], n - 3, n);
      if (m == 4) tmp = tmp ^ rk[i+1];
      tmp = tmp ^ rotl(tmp, n - 1, n);
      zb = zw[6'(61 - (i % 62))];
      rk[i+m] = (~rk[i] ^ tmp ^ 64'(zb) ^ 64'd3) & msk(n);
    end
  endtask

  task automatic model_run(input logic [63:0] xi, input logic [63:0] yi, input bit enc,
                           input int n, input int t, output logic [63:0] xo, output logic [63:0] yo);
    logic [63:0] xv, yv, tmp;
    xv = xi & msk(n);
    yv = yi & msk(n);
    for (int r = 0; r < t; r++) begin
      if (enc) begin
        tmp = xv; xv = (yv ^ ff(xv, n) ^ rk[r]) & msk(n); yv = tmp;
      end else begin
        tmp = yv; yv = (xv ^ ff(yv, n) ^ rk[t-1-r]) & msk(n); xv = tmp;
      end
    end
    xo = xv;
    yo = yv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [3:0][63:0] kv, input bit with_data);
    expand(kv, N0, M0, T0, 4);
    key = kv;
    newKey = 1'b1;
    newData = with_data;
    inData = {$urandom, $urandom, $urandom, $urandom};
    step();
    newKey = 1'b0;
    newData = 1'b0;
    exp_lk = 1'b0; exp_ld = 1'b0; exp_dk = 1'b0;
    for (int c = 1; c < T0 - M0; c++) begin
      newData = 1'($urandom);
      step();
    end
    newData = 1'b0;
    step();
    exp_dk = 1'b1; exp_lk = 1'b1; exp_ld = 1'b1;
  endtask

  task automatic run_block(input logic [127:0] blk, input bit enc, input int hold);
    logic [63:0] xo, yo;
    bit e;
    e = enc;
`ifndef SIMON_DEC_EN
    e = 1'b1;
`endif
    model_run(blk[127:64], blk[63:0], e, N0, T0, xo, yo);
    inData = blk;
    enc_dec = enc;
    newData = 1'b1;
    step();
    newData = 1'b0;
    exp_lk = 1'b0; exp_ld = 1'b0;
    for (int c = 1; c <= T0; c++) begin
      newKey = 1'($urandom); newData = 1'($urandom); readData = 1'($urandom);
      step();
    end
    newKey = 1'b0; newData = 1'b0; readData = 1'b0;
    exp_out = {xo, yo};
    exp_dd = 1'b1;
    for (int h = 0; h < hold; h++) begin
      newData = 1'($urandom);
      step();
    end
    newData = 1'b0;
    readData = 1'b1;
    step();
    readData = 1'b0;
    exp_dd = 1'b0; exp_lk = 1'b1; exp_ld = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mx, my;
    logic [3:0][63:0] rkey;
    logic [127:0] rblk;

    zt[0] = 62'b11111010001001010110000111001101111101000100101011000011100110;
    zt[1] = 62'b10001110111110010011000010110101000111011111001001100001011010;
    zt[2] = 62'b10101111011100000011010010011000101000010001111110010110110011;
    zt[3] = 62'b11011011101011000110010111100000010010001010011100110100001111;
    zt[4] = 62'b11010001111001101011011000100000010111000011001010010011101111;

    R = 1'b1;
    newKey = 0; newData = 0; enc_dec = 1; readData = 0; key = '0; inData = '0;
    s_newKey = 0; s_newData = 0; s_enc = 1; s_read = 0; s_key = '0; s_in = '0;
    exp_lk = 1'b1; exp_ld = 1'b0; exp_dk = 1'b0; exp_dd = 1'b0; exp_out = '0;

    // Pin the model against published vectors.
    expand({48'h0, 16'h1918, 48'h0, 16'h1110, 48'h0, 16'h0908, 48'h0, 16'h0100}, 16, 4, 32, 0);
    model_run(64'h6565, 64'h6877, 1'b1, 16, 32, mx, my);
    check("model_32_64", 128'({mx[15:0], my[15:0]}), 128'(32'hc69be9bb));
    expand(K0, N0, M0, T0, 4);
    model_run(PT[127:64], PT[63:0], 1'b1, N0, T0, mx, my);
    check("model_128_256_enc", {mx, my}, CT);
    model_run(CT[127:64], CT[63:0], 1'b0, N0, T0, mx, my);
    check("model_128_256_dec", {mx, my}, PT);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_loadKey", 128'(loadKey), 128'(1));
    check("rst_outData", 128'(outData), 128'(0));
    step();
    R = 1'b0;
    step();

    // SIMON32/64 instance.
    s_key = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
    s_newKey = 1'b1;
    step();
    s_newKey = 1'b0;
    cnt = 0;
    while (!s_dk && cnt < 100) begin step(); cnt++; end
    check("s_key_latency", 128'(cnt), 128'(28));
    s_in = {16'h6565, 16'h6877};
    s_newData = 1'b1;
    step();
    s_newData = 1'b0;
    cnt = 0;
    while (!s_dd && cnt < 100) begin step(); cnt++; end
    check("s_data_latency", 128'(cnt), 128'(32));
    check("s_ct", 128'(s_out), 128'(32'hc69be9bb));
    s_read = 1'b1;
    step();
    s_read = 1'b0;
    check("s_loadData_after_read", 128'(s_ld), 128'(1));

    // SIMON128/256 known answers, DONE held 20 cycles.
    load_key(K0, 1'b0);
    run_block(PT, 1'b1, 20);
    check("ct_128_256", 128'(outData), CT);
    run_block(CT, 1'b0, 0);
`ifdef SIMON_DEC_EN
    check("pt_128_256", 128'(outData), PT);
`endif

    // Randomized traffic, including key-and-block collisions.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 4; i++) rkey[i] = {$urandom, $urandom};
        load_key(rkey, 1'($urandom));
      end
      rblk = {$urandom, $urandom, $urandom, $urandom};
      run_block(rblk, 1'($urandom), $urandom_range(0, 4));
    end
    for (int i = 0; i < 4; i++) rkey[i] = {$urandom, $urandom};
    load_key(rkey, 1'b1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1);

    // Reset at round count 30.
    inData = PT;
    enc_dec = 1'b1;
    newData = 1'b1;
    step();
    newData = 1'b0;
    exp_lk = 1'b0; exp_ld = 1'b0;
    repeat (30) step();
    R = 1'b1;
    #1;
    exp_lk = 1'b1; exp_ld = 1'b0; exp_dk = 1'b0; exp_dd = 1'b0; exp_out = '0;
    check("midrst_loadKey", 128'(loadKey), 128'(1));
    check("midrst_outData", 128'(outData), 128'(0));
    repeat (2) step();
    R = 1'b0;
    newData = 1'b1;
    repeat (3) step();
    newData = 1'b0;
    step();
    check("nokey_loadData", 128'(loadData), 128'(0));
    load_key(K0, 1'b0);
    run_block(PT, 1'b1, 2);
    check("ct_after_reload", 128'(outData), CT);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
